burst_ram_arbiter: RTL and testbench

Two-client arbiter between the instruction cache, the data cache and the single BurstRAM command port. Latches one pending request per client, grants one burst at a time, and steers command, address and write beats to BurstRAM. It returns read beats and completion (busy) to the owning client. Sits directly downstream of both cache controllers, replacing direct shared wiring of their `br_*` outputs.

---
 rtl/burst_ram_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: shares one BurstRAM command port between icache and dcache.
// Latches one request per client, grants one burst at a time, routes beats back.
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   i_cmd_en/i_addr          icache read request (pulse)
//   i_rd_data_valid/i_busy   icache read beat strobe / request outstanding
//   d_cmd_en/d_cmd/d_addr    dcache request (d_cmd 0 read, 1 write)
//   d_wr_data/d_data_mask    dcache write beat, consumed while d_wr_ready=1
//   d_wr_ready               write beat taken this cycle
//   d_rd_data_valid/d_busy   dcache read beat strobe / request outstanding
//   rd_data                  read data broadcast to both clients
//   br_*                     BurstRAM command/write side and read/busy returns
//
// Build option: define BURST_ARB_ROUND_ROBIN_EN to alternate winners on a tie;
// otherwise dcache always wins a tie.

module burst_ram_arbiter #(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        i_addr,
    output logic                                 i_rd_data_valid,
    output logic                                 i_busy,
    input  logic                                 d_cmd_en,
    input  logic                                 d_cmd,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        d_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   d_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] d_data_mask,
    output logic                                 d_wr_ready,
    output logic                                 d_rd_data_valid,
    output logic                                 d_busy,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   rd_data,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy
);

    localparam int AW = RAM_DEPTH_BITWIDTH;
    localparam int CW = $clog2(RAM_BURST_DATA_COUNT);
    localparam logic [CW-1:0] LAST = CW'(RAM_BURST_DATA_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WRITE,
        READ_WAIT,
        DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;  // 1: dcache owns the burst

    logic          i_pend_q;
    logic [AW-1:0] i_addr_q;
    logic          d_pend_q;
    logic          d_cmd_q;
    logic [AW-1:0] d_addr_q;

    logic i_acc, d_acc;
    logic grant, pick_d, done, own_wr;

    assign i_busy = i_pend_q | ((state_q != IDLE) & ~owner_q);
    assign d_busy = d_pend_q | ((state_q != IDLE) & owner_q);

    // A pulse while busy is dropped, so cmd/addr stay stable for the burst.
    assign i_acc  = i_cmd_en & ~i_busy;
    assign d_acc  = d_cmd_en & ~d_busy;
    assign grant  = (state_q == IDLE) & ~br_busy & (i_pend_q | d_pend_q);
    assign own_wr = owner_q & d_cmd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_pend_q <= 1'b0;
            i_addr_q <= '0;
            d_pend_q <= 1'b0;
            d_cmd_q  <= 1'b0;
            d_addr_q <= '0;
        end else begin
            if (i_acc) begin
                i_pend_q <= 1'b1;
                i_addr_q <= i_addr;
            end else if (done && !owner_q) begin
                i_pend_q <= 1'b0;
            end
            if (d_acc) begin
                d_pend_q <= 1'b1;
                d_cmd_q  <= d_cmd;
                d_addr_q <= d_addr;
            end else if (done && owner_q) begin
                d_pend_q <= 1'b0;
            end
        end
    end

`ifdef BURST_ARB_ROUND_ROBIN_EN
    logic last_d_q;  // 1: dcache was granted last

    assign pick_d = d_pend_q & (~i_pend_q | ~last_d_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d_q <= 1'b0;
        end else if (grant) begin
            last_d_q <= pick_d;
        end
    end
`else
    assign pick_d = d_pend_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d = pick_d;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Beat 0 of a write goes out alongside the command.
                if (own_wr) begin
                    cnt_d   = CW'(1);
                    state_d = WRITE;
                end else begin
                    state_d = READ_WAIT;
                end
            end
            WRITE: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            READ_WAIT: begin
                if (br_rd_data_valid) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (!br_busy) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        br_cmd_en       = 1'b0;
        br_cmd          = 1'b0;
        br_addr         = '0;
        d_wr_ready      = 1'b0;
        i_rd_data_valid = 1'b0;
        d_rd_data_valid = 1'b0;
        unique case (state_q)
            ISSUE: begin
                br_cmd_en  = 1'b1;
                br_cmd     = own_wr;
                br_addr    = owner_q ? d_addr_q : i_addr_q;
                d_wr_ready = own_wr;
            end
            WRITE: d_wr_ready = 1'b1;
            READ_WAIT: begin
                i_rd_data_valid = br_rd_data_valid & ~owner_q;
                d_rd_data_valid = br_rd_data_valid & owner_q;
            end
            default: ;
        endcase
    end

    assign rd_data      = br_rd_data;
    assign br_wr_data   = d_wr_data;
    assign br_data_mask = d_wr_ready ? d_data_mask : '0;

`ifndef SYNTHESIS
    a_i_drop: assert property (@(posedge clk) disable iff (!rst)
        !(i_cmd_en && i_busy));
    a_d_drop: assert property (@(posedge clk) disable iff (!rst)
        !(d_cmd_en && d_busy));
    a_stray_rd: assert property (@(posedge clk) disable iff (!rst)
        br_rd_data_valid |-> (state_q == READ_WAIT));
`endif

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter: scoreboard bench for burst_ram_arbiter
// with a small behavioural BurstRAM model.

module tb_burst_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 64;
    localparam int MW = DW / 8;
    localparam int N  = 4;
    localparam int WB = N + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_cmd_en = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_rd_data_valid, i_busy;
    logic          d_cmd_en = 1'b0;
    logic          d_cmd = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wr_data;
    logic [MW-1:0] d_data_mask;
    logic          d_wr_ready, d_rd_data_valid, d_busy;
    logic [DW-1:0] rd_data;
    logic          br_cmd, br_cmd_en;
    logic [AW-1:0] br_addr;
    logic [DW-1:0] br_wr_data;
    logic [MW-1:0] br_data_mask;
    logic [DW-1:0] br_rd_data;
    logic          br_rd_data_valid, br_busy;

    always #5 clk = ~clk;

    burst_ram_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .i_cmd_en         (i_cmd_en),
        .i_addr           (i_addr),
        .i_rd_data_valid  (i_rd_data_valid),
        .i_busy           (i_busy),
        .d_cmd_en         (d_cmd_en),
        .d_cmd            (d_cmd),
        .d_addr           (d_addr),
        .d_wr_data        (d_wr_data),
        .d_data_mask      (d_data_mask),
        .d_wr_ready       (d_wr_ready),
        .d_rd_data_valid  (d_rd_data_valid),
        .d_busy           (d_busy),
        .rd_data          (rd_data),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .br_busy          (br_busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mkdata(logic [AW-1:0] a, int b);
        return {16'hC0DE, 12'h000, a, 32'(b)};
    endfunction

    // BurstRAM model: read beats at +2..+5 after the command, busy +1..+5;
    // write keeps busy for +1..+WB.
    int            ph;
    logic          rm_rd;
    logic [AW-1:0] rm_addr;
    logic          bb_force = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph      <= 0;
            rm_rd   <= 1'b0;
            rm_addr <= '0;
        end else if (br_cmd_en) begin
            ph      <= 1;
            rm_rd   <= !br_cmd;
            rm_addr <= br_addr;
        end else if (ph != 0) begin
            if (rm_rd ? (ph == N + 1) : (ph == WB)) ph <= 0;
            else ph <= ph + 1;
        end
    end

    assign br_busy          = bb_force | (ph != 0);
    assign br_rd_data_valid = rm_rd && (ph >= 2);
    assign br_rd_data       = mkdata(rm_addr, ph - 2);

    logic [DW-1:0] wbeat [N];
    logic [MW-1:0] wmask [N];
    int            wi;

    always @(posedge clk or negedge rst) begin
        if (!rst) wi <= 0;
        else if (d_wr_ready) wi <= (wi == N - 1) ? 0 : wi + 1;
    end

    assign d_wr_data   = wbeat[wi];
    assign d_data_mask = wmask[wi];

    typedef struct packed {
        logic          cmd;
        logic [AW-1:0] addr;
        int            at;
    } cmd_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [MW-1:0] m;
    } wb_t;

    cmd_t          cmd_q [$];
    logic [DW-1:0] iq [$];
    logic [DW-1:0] dq [$];
    wb_t           wq [$];
    logic          last_d = 1'b0;

    always @(negedge clk) begin
        cmd_t c;
        wb_t  w;
        if (rst) begin
            if (br_cmd_en) begin
                chk("cmd_expected", 64'(cmd_q.size() != 0), 64'd1);
                if (cmd_q.size() != 0) begin
                    c = cmd_q.pop_front();
                    chk("br_cmd", 64'(br_cmd), 64'(c.cmd));
                    chk("br_addr", 64'(br_addr), 64'(c.addr));
                    if (c.at >= 0) chk("cmd_cycle", 64'(cyc), 64'(c.at));
                end
            end
            if (i_rd_data_valid) begin
                chk("i_beat_expected", 64'(iq.size() != 0), 64'd1);
                if (iq.size() != 0) chk("i_beat", rd_data, iq.pop_front());
            end
            if (d_rd_data_valid) begin
                chk("d_beat_expected", 64'(dq.size() != 0), 64'd1);
                if (dq.size() != 0) chk("d_beat", rd_data, dq.pop_front());
            end
            if (d_wr_ready) begin
                chk("wr_beat_expected", 64'(wq.size() != 0), 64'd1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    chk("wr_data", br_wr_data, w.d);
                    chk("wr_mask", 64'(br_data_mask), 64'(w.m));
                end
            end else begin
                chk("mask_off", 64'(br_data_mask), 64'd0);
            end
        end
    end

    function automatic logic [63:0] outs();
        return 64'({br_cmd_en, br_cmd, br_addr, d_wr_ready, i_rd_data_valid,
                    d_rd_data_valid, i_busy, d_busy, br_data_mask});
    endfunction

    function automatic logic tie_d();
`ifdef BURST_ARB_ROUND_ROBIN_EN
        return !last_d;
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_clr();
        tick();
        i_cmd_en = 1'b0;
        d_cmd_en = 1'b0;
    endtask

    task automatic req_i(input logic [AW-1:0] a, input int at);
        cmd_t c;
        i_cmd_en = 1'b1;
        i_addr   = a;
        c.cmd = 1'b0;
        c.addr = a;
        c.at = at;
        cmd_q.push_back(c);
        for (int b = 0; b < N; b++) iq.push_back(mkdata(a, b));
        last_d = 1'b0;
    endtask

    task automatic req_d(input logic wr, input logic [AW-1:0] a,
                         input int at);
        cmd_t c;
        wb_t  w;
        d_cmd_en = 1'b1;
        d_cmd    = wr;
        d_addr   = a;
        c.cmd = wr;
        c.addr = a;
        c.at = at;
        cmd_q.push_back(c);
        for (int b = 0; b < N; b++) begin
            if (wr) begin
                w.d = wbeat[b];
                w.m = wmask[b];
                wq.push_back(w);
            end else begin
                dq.push_back(mkdata(a, b));
            end
        end
        last_d = 1'b1;
    endtask

    task automatic wait_idle(input logic is_d, input int budget,
                             output int fell);
        fell = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (!(is_d ? d_busy : i_busy)) begin
                fell = cyc;
                break;
            end
        end
        if (fell < 0)
            chk(is_d ? "d_busy_wait" : "i_busy_wait",
                64'(is_d ? d_busy : i_busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, f;
        logic first_d;

        for (int b = 0; b < N; b++) begin
            wbeat[b] = 64'h11 * 64'(b + 1);
            wmask[b] = 8'hFF;
        end

        repeat (3) tick();
        chk("reset_outs", outs(), 64'd0);
        rst = 1'b1;
        repeat (2) tick();

        // icache read alone
        p = cyc;
        req_i(4'd5, p + 2);
        tick_clr();
        chk("i_busy_after_pulse", 64'(i_busy), 64'd1);
        chk("d_busy_quiet", 64'(d_busy), 64'd0);
        wait_idle(1'b0, 40, f);
        chk("i_busy_fall", 64'(f), 64'(p + 8));
        chk("i_beats_left", 64'(iq.size()), 64'd0);
        repeat (2) tick();

        // dcache write
        p = cyc;
        req_d(1'b1, 4'd3, p + 2);
        tick_clr();
        for (int k = 1; k <= 6; k++) begin
            chk("wr_ready_window", 64'(d_wr_ready), 64'(k >= 2 && k <= 5));
            chk("d_busy_in_burst", 64'(d_busy), 64'd1);
            tick();
        end
        chk("d_busy_while_br_busy", 64'({br_busy, d_busy}), 64'b11);
        wait_idle(1'b1, 40, f);
        chk("d_busy_fall", 64'(f), 64'(p + 11));
        chk("wr_beats_left", 64'(wq.size()), 64'd0);
        repeat (2) tick();

        // two ties in a row
        for (int t = 0; t < 2; t++) begin
            p = cyc;
            first_d = tie_d();
            if (first_d) begin
                req_d(1'b0, 4'(9 + t), p + 2);
                req_i(4'(7 - t), -1);
            end else begin
                req_i(4'(7 - t), p + 2);
                req_d(1'b0, 4'(9 + t), -1);
            end
            tick_clr();
            wait_idle(first_d, 40, f);
            chk("tie_winner_fall", 64'(f), 64'(p + 8));
            chk("tie_loser_pending", 64'(first_d ? i_busy : d_busy), 64'd1);
            wait_idle(!first_d, 40, f);
            chk("tie_beats_left", 64'(iq.size() + dq.size()), 64'd0);
            repeat (2) tick();
        end

        // br_busy held high for 10 cycles
        p = cyc;
        bb_force = 1'b1;
        req_i(4'd6, p + 11);
        tick_clr();
        repeat (9) tick();
        bb_force = 1'b0;
        wait_idle(1'b0, 40, f);
        chk("hold_i_fall", 64'(f), 64'(p + 17));
        repeat (2) tick();

        // reset during the second read beat
        p = cyc;
        req_i(4'd10, p + 2);
        tick_clr();
        while (cyc < p + 5) tick();
        chk("second_beat_live", 64'(i_rd_data_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_burst_reset_outs", outs(), 64'd0);
        cmd_q.delete();
        iq.delete();
        last_d = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        p = cyc;
        req_i(4'd4, p + 2);
        tick_clr();
        wait_idle(1'b0, 40, f);
        chk("post_reset_fall", 64'(f), 64'(p + 8));
        repeat (2) tick();

        // back-to-back dcache: write, then read on the cycle busy falls
        wmask[0] = 8'h0F;
        wmask[1] = 8'hF0;
        wmask[2] = 8'hA5;
        wmask[3] = 8'h5A;
        for (int b = 0; b < N; b++) wbeat[b] = 64'hBEEF_0000_0000_0000 | 64'(b);
        p = cyc;
        req_d(1'b1, 4'd1, p + 2);
        tick_clr();
        wait_idle(1'b1, 40, f);
        chk("b2b_first_fall", 64'(f), 64'(p + 11));
        req_d(1'b0, 4'd8, f + 2);
        tick_clr();
        chk("b2b_accepted", 64'(d_busy), 64'd1);
        wait_idle(1'b1, 40, f);
        repeat (2) tick();

        chk("cmd_left", 64'(cmd_q.size()), 64'd0);
        chk("rd_left", 64'(iq.size() + dq.size()), 64'd0);
        chk("wr_left", 64'(wq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
